// File: rtl/rat_io_responder.sv
// RAT MCU I/O responder: LED and seven-segment output ports, switch/button input ports,
// a prescaled auto-reload timer, and a level interrupt built from two pend bits.
module rat_io_responder #(
  parameter int unsigned PRESCALE   = 1000,
  parameter logic [7:0]  LEDS_ID    = 8'h40,
  parameter logic [7:0]  SSEG_ID    = 8'h81,
  parameter logic [7:0]  TMR_RLD_ID = 8'h10,
  parameter logic [7:0]  TMR_CTL_ID = 8'h11,
  parameter logic [7:0]  INT_ACK_ID = 8'h12,
  parameter logic [7:0]  SW_ID      = 8'h20,
  parameter logic [7:0]  BTN_ID     = 8'h21,
  parameter logic [7:0]  STAT_ID    = 8'h22
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  output logic [7:0] IN_PORT,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_DATA,
  output logic       INTERUPT
);

  localparam int unsigned      PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [7:0]      tmr_rld;
  logic [7:0]      tmr_cnt;
  logic [PS_W-1:0] ps_cnt;
  logic            tmr_en;
  logic            tmr_pend;
  logic            btn_pend;
  logic [3:0]      btn_meta;
  logic [3:0]      btn_sync;
  logic            btn0_prev;

  logic wr_leds, wr_sseg, wr_rld, wr_ctl, wr_ack;
  logic tick, tmr_set, btn_set;

  assign wr_leds = IO_STRB && (PORT_ID == LEDS_ID);
  assign wr_sseg = IO_STRB && (PORT_ID == SSEG_ID);
  assign wr_rld  = IO_STRB && (PORT_ID == TMR_RLD_ID);
  assign wr_ctl  = IO_STRB && (PORT_ID == TMR_CTL_ID);
  assign wr_ack  = IO_STRB && (PORT_ID == INT_ACK_ID);

  // A reload write pre-empts a coincident tick, so it also suppresses the terminal-count pend.
  assign tick    = tmr_en && (ps_cnt == PS_LAST);
  assign tmr_set = tick && (tmr_cnt == 8'h00) && !wr_rld;
  assign btn_set = btn_sync[0] && !btn0_prev;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      LEDS      <= 8'h00;
      SSEG_DATA <= 8'h00;
    end else begin
      if (wr_leds) LEDS <= OUT_PORT;
      if (wr_sseg) SSEG_DATA <= OUT_PORT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmr_rld <= 8'h00;
      tmr_cnt <= 8'h00;
      ps_cnt  <= '0;
      tmr_en  <= 1'b0;
    end else begin
      if (wr_rld) begin
        tmr_rld <= OUT_PORT;
        tmr_cnt <= OUT_PORT;
        ps_cnt  <= '0;
      end else if (tmr_en) begin
        ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
        if (tick) tmr_cnt <= (tmr_cnt == 8'h00) ? tmr_rld : tmr_cnt - 8'd1;
      end
      if (wr_ctl) tmr_en <= OUT_PORT[0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_meta  <= 4'h0;
      btn_sync  <= 4'h0;
      btn0_prev <= 1'b0;
    end else begin
      btn_meta  <= BUTTONS;
      btn_sync  <= btn_meta;
      btn0_prev <= btn_sync[0];
    end
  end

  // Set beats acknowledge when both hit the same pend bit on one edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmr_pend <= 1'b0;
      btn_pend <= 1'b0;
    end else begin
      if (tmr_set) tmr_pend <= 1'b1;
      else if (wr_ack && OUT_PORT[0]) tmr_pend <= 1'b0;
      if (btn_set) btn_pend <= 1'b1;
      else if (wr_ack && OUT_PORT[1]) btn_pend <= 1'b0;
    end
  end

  assign INTERUPT = tmr_pend | btn_pend;

  always_comb begin
    IN_PORT = 8'h00;
    if (PORT_ID == SW_ID)           IN_PORT = SWITCHES;
    else if (PORT_ID == BTN_ID)     IN_PORT = {4'h0, btn_sync};
    else if (PORT_ID == STAT_ID)    IN_PORT = {5'h00, tmr_en, btn_pend, tmr_pend};
    else if (PORT_ID == TMR_RLD_ID) IN_PORT = tmr_cnt;
  end

endmodule

// File: tb/tb_rat_io_responder.sv
// Self-checking bench for rat_io_responder with PRESCALE=4; timer expectations come from
// counting enabled clock edges and applying the period/reload arithmetic directly.
module tb_rat_io_responder;

  localparam int unsigned PS = 4;
  localparam logic [7:0] LEDS_ID = 8'h40, SSEG_ID = 8'h81, TMR_RLD_ID = 8'h10,
                         TMR_CTL_ID = 8'h11, INT_ACK_ID = 8'h12, SW_ID = 8'h20,
                         BTN_ID = 8'h21, STAT_ID = 8'h22;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] PORT_ID, OUT_PORT, SWITCHES;
  logic       IO_STRB;
  logic [3:0] BUTTONS;
  logic [7:0] IN_PORT, LEDS, SSEG_DATA;
  logic       INTERUPT;

  int n_checks = 0;
  int n_pass   = 0;

  rat_io_responder #(.PRESCALE(PS)) dut (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
    .SWITCHES(SWITCHES), .BUTTONS(BUTTONS), .IN_PORT(IN_PORT), .LEDS(LEDS),
    .SSEG_DATA(SSEG_DATA), .INTERUPT(INTERUPT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic io_write(input logic [7:0] id, input logic [7:0] d);
    PORT_ID = id; OUT_PORT = d; IO_STRB = 1'b1;
    step();
    IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
  endtask

  task automatic do_reset();
    RESET = 1'b1; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00; BUTTONS = 4'h0;
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; PORT_ID = LEDS_ID; OUT_PORT = 8'h5A; IO_STRB = 1'b1; BUTTONS = 4'hF;
    SWITCHES = 8'h00;
    step(); step();
    RESET = 1'b0; IO_STRB = 1'b0; BUTTONS = 4'h0;
    n_checks++; if (LEDS !== 8'h00) $display("FAIL reset_leds: got %h want 00", LEDS); else n_pass++;
    n_checks++; if (SSEG_DATA !== 8'h00) $display("FAIL reset_sseg: got %h want 00", SSEG_DATA); else n_pass++;
    n_checks++; if (INTERUPT !== 1'b0) $display("FAIL reset_int: got %b want 0", INTERUPT); else n_pass++;
    PORT_ID = STAT_ID; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("FAIL reset_stat: got %h want 00", IN_PORT); else n_pass++;
    PORT_ID = TMR_RLD_ID; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("FAIL reset_cnt: got %h want 00", IN_PORT); else n_pass++;
    PORT_ID = BTN_ID; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("FAIL reset_btn: got %h want 00", IN_PORT); else n_pass++;
    PORT_ID = 8'h00;
  endtask

  task automatic test_port_writes();
    logic [7:0] exp_leds, exp_sseg, id, d;
    logic strb;
    exp_leds = 8'h00; exp_sseg = 8'h00;
    io_write(LEDS_ID, 8'hA5); exp_leds = 8'hA5;
    n_checks++; if (LEDS !== 8'hA5) $display("FAIL leds_write: got %h want a5", LEDS); else n_pass++;
    io_write(8'h41, 8'h3C);
    n_checks++; if (LEDS !== 8'hA5) $display("FAIL leds_unmatched: got %h want a5", LEDS); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom); strb = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: id = LEDS_ID;
        1: id = SSEG_ID;
        2: id = 8'h41;
        default: id = 8'($urandom);
      endcase
      if (id inside {TMR_RLD_ID, TMR_CTL_ID, INT_ACK_ID}) id = 8'h00;
      PORT_ID = id; OUT_PORT = d; IO_STRB = strb;
      step();
      IO_STRB = 1'b0;
      if (strb && id == LEDS_ID) exp_leds = d;
      if (strb && id == SSEG_ID) exp_sseg = d;
      n_checks++; if (LEDS !== exp_leds) $display("FAIL rand_leds[%0d]: got %h want %h", i, LEDS, exp_leds); else n_pass++;
      n_checks++; if (SSEG_DATA !== exp_sseg) $display("FAIL rand_sseg[%0d]: got %h want %h", i, SSEG_DATA, exp_sseg); else n_pass++;
    end
    PORT_ID = 8'h00;
  endtask

  task automatic test_in_port();
    logic [7:0] sw, id;
    SWITCHES = 8'h4F; PORT_ID = SW_ID; #1;
    n_checks++; if (IN_PORT !== 8'h4F) $display("FAIL sw_read: got %h want 4f", IN_PORT); else n_pass++;
    PORT_ID = 8'h99; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("FAIL unmapped_read: got %h want 00", IN_PORT); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      step();
      sw = 8'($urandom); SWITCHES = sw; PORT_ID = SW_ID; #1;
      n_checks++; if (IN_PORT !== sw) $display("FAIL rand_sw[%0d]: got %h want %h", i, IN_PORT, sw); else n_pass++;
      id = 8'($urandom);
      if (id inside {BTN_ID, STAT_ID, TMR_RLD_ID}) id = 8'h30;
      PORT_ID = id; #1;
      n_checks++;
      if (IN_PORT !== ((id == SW_ID) ? sw : 8'h00))
        $display("FAIL rand_id_read[%0d]: id %h got %h want %h", i, id, IN_PORT, (id == SW_ID) ? sw : 8'h00);
      else n_pass++;
    end
    PORT_ID = 8'h00;
  endtask

  task automatic test_timer_period();
    int n;
    do_reset();
    io_write(TMR_RLD_ID, 8'd3);
    io_write(TMR_CTL_ID, 8'h01);
    n = 0;
    while (!INTERUPT && n < 100) begin step(); n++; end
    n_checks++; if (n !== 16) $display("FAIL tmr_first_rise: got %0d clocks want 16", n); else n_pass++;
    PORT_ID = STAT_ID; #1;
    n_checks++; if (IN_PORT !== 8'h05) $display("FAIL tmr_stat: got %h want 05", IN_PORT); else n_pass++;
    io_write(INT_ACK_ID, 8'h01);
    n_checks++; if (INTERUPT !== 1'b0) $display("FAIL tmr_ack: got %b want 0", INTERUPT); else n_pass++;
    n = 1;
    while (!INTERUPT && n < 100) begin step(); n++; end
    n_checks++; if (n !== 16) $display("FAIL tmr_second_rise: got %0d clocks want 16", n); else n_pass++;
  endtask

  task automatic test_timer_random();
    int r, period;
    logic [7:0] e;
    for (int it = 0; it < 4; it++) begin
      r = (it == 0) ? 0 : int'($urandom_range(1, 9));
      period = int'(PS) * (r + 1);
      do_reset();
      io_write(TMR_RLD_ID, 8'(r));
      io_write(TMR_CTL_ID, 8'h01);
      PORT_ID = TMR_RLD_ID;
      for (int n = 1; n <= period; n++) begin
        step();
        e = 8'(r - ((n / int'(PS)) % (r + 1)));
        n_checks++; if (IN_PORT !== e) $display("FAIL rand_cnt r=%0d n=%0d: got %h want %h", r, n, IN_PORT, e); else n_pass++;
        n_checks++;
        if (INTERUPT !== (n >= period)) $display("FAIL rand_int r=%0d n=%0d: got %b want %b", r, n, INTERUPT, n >= period);
        else n_pass++;
      end
      io_write(INT_ACK_ID, 8'h01);
      n_checks++; if (INTERUPT !== 1'b0) $display("FAIL rand_ack r=%0d: got %b want 0", r, INTERUPT); else n_pass++;
      repeat (period - 2) step();
      n_checks++; if (INTERUPT !== 1'b0) $display("FAIL rand_early r=%0d: got %b want 0", r, INTERUPT); else n_pass++;
      step();
      n_checks++; if (INTERUPT !== 1'b1) $display("FAIL rand_rerise r=%0d: got %b want 1", r, INTERUPT); else n_pass++;
    end
    PORT_ID = 8'h00;
  endtask

  task automatic test_freeze();
    int r, j, q, en_edges, period;
    logic [7:0] e;
    do_reset();
    r = int'($urandom_range(2, 9)); j = int'($urandom_range(0, 10)); q = int'($urandom_range(1, 12));
    period = int'(PS) * (r + 1);
    io_write(TMR_RLD_ID, 8'(r));
    io_write(TMR_CTL_ID, 8'h01);
    repeat (j) step();
    io_write(TMR_CTL_ID, 8'h00);
    en_edges = j + 1;
    e = 8'(r - ((en_edges / int'(PS)) % (r + 1)));
    PORT_ID = TMR_RLD_ID;
    repeat (8) step();
    n_checks++; if (IN_PORT !== e) $display("FAIL freeze_cnt: got %h want %h", IN_PORT, e); else n_pass++;
    n_checks++;
    if (INTERUPT !== (en_edges >= period)) $display("FAIL freeze_int: got %b want %b", INTERUPT, en_edges >= period);
    else n_pass++;
    io_write(TMR_CTL_ID, 8'h01);
    PORT_ID = TMR_RLD_ID;
    repeat (q) step();
    en_edges += q;
    e = 8'(r - ((en_edges / int'(PS)) % (r + 1)));
    n_checks++; if (IN_PORT !== e) $display("FAIL resume_cnt: got %h want %h", IN_PORT, e); else n_pass++;
    n_checks++;
    if (INTERUPT !== (en_edges >= period)) $display("FAIL resume_int: got %b want %b", INTERUPT, en_edges >= period);
    else n_pass++;
    PORT_ID = 8'h00;
  endtask

  task automatic test_button();
    logic [3:0] b;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b = 4'($urandom) & 4'hE;
      BUTTONS = b;
      step(); step();
      PORT_ID = BTN_ID; #1;
      n_checks++; if (IN_PORT !== {4'h0, b}) $display("FAIL btn_read[%0d]: got %h want %h", i, IN_PORT, {4'h0, b}); else n_pass++;
      n_checks++; if (INTERUPT !== 1'b0) $display("FAIL btn_noint[%0d]: got %b want 0", i, INTERUPT); else n_pass++;
    end
    BUTTONS = 4'h0;
    repeat (3) step();
    BUTTONS = 4'h1;
    step(); step();
    n_checks++; if (INTERUPT !== 1'b0) $display("FAIL btn_latency: got %b want 0", INTERUPT); else n_pass++;
    step();
    n_checks++; if (INTERUPT !== 1'b1) $display("FAIL btn_int: got %b want 1", INTERUPT); else n_pass++;
    PORT_ID = STAT_ID; #1;
    n_checks++; if (IN_PORT !== 8'h02) $display("FAIL btn_stat: got %h want 02", IN_PORT); else n_pass++;
    BUTTONS = 4'h0;
    repeat (3) step();
    BUTTONS = 4'h1;
    step(); step();
    PORT_ID = INT_ACK_ID; OUT_PORT = 8'h02; IO_STRB = 1'b1;
    step();
    IO_STRB = 1'b0; OUT_PORT = 8'h00; PORT_ID = STAT_ID; #1;
    n_checks++; if (IN_PORT !== 8'h02) $display("FAIL btn_set_wins: got %h want 02", IN_PORT); else n_pass++;
    io_write(INT_ACK_ID, 8'h02);
    PORT_ID = STAT_ID; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("FAIL btn_ack_stat: got %h want 00", IN_PORT); else n_pass++;
    n_checks++; if (INTERUPT !== 1'b0) $display("FAIL btn_ack_int: got %b want 0", INTERUPT); else n_pass++;
    BUTTONS = 4'h0; PORT_ID = 8'h00;
  endtask

  task automatic test_reset_midcount();
    int n;
    bit seen;
    do_reset();
    io_write(TMR_RLD_ID, 8'd9);
    io_write(TMR_CTL_ID, 8'h01);
    io_write(LEDS_ID, 8'h77);
    n = 0;
    while (!INTERUPT && n < 60) begin step(); n++; end
    repeat (3) step();
    n_checks++; if (INTERUPT !== 1'b1) $display("FAIL mid_pend: got %b want 1", INTERUPT); else n_pass++;
    RESET = 1'b1; PORT_ID = LEDS_ID; OUT_PORT = 8'hFF; IO_STRB = 1'b1;
    step();
    RESET = 1'b0; IO_STRB = 1'b0; OUT_PORT = 8'h00;
    n_checks++; if (LEDS !== 8'h00) $display("FAIL mid_leds: got %h want 00", LEDS); else n_pass++;
    n_checks++; if (INTERUPT !== 1'b0) $display("FAIL mid_int: got %b want 0", INTERUPT); else n_pass++;
    PORT_ID = STAT_ID; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("FAIL mid_stat: got %h want 00", IN_PORT); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin step(); if (INTERUPT !== 1'b0) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL mid_quiet: got int seen %b want 0", seen); else n_pass++;
    PORT_ID = TMR_RLD_ID; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("FAIL mid_cnt: got %h want 00", IN_PORT); else n_pass++;
    PORT_ID = 8'h00;
  endtask

  task automatic test_reload_on_tick();
    do_reset();
    io_write(TMR_RLD_ID, 8'd1);
    io_write(TMR_CTL_ID, 8'h01);
    repeat (7) step();
    PORT_ID = TMR_RLD_ID; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("FAIL rot_pre_cnt: got %h want 00", IN_PORT); else n_pass++;
    io_write(TMR_RLD_ID, 8'd5);
    PORT_ID = TMR_RLD_ID; #1;
    n_checks++; if (IN_PORT !== 8'h05) $display("FAIL rot_cnt: got %h want 05", IN_PORT); else n_pass++;
    PORT_ID = STAT_ID; #1;
    n_checks++; if (IN_PORT !== 8'h04) $display("FAIL rot_stat: got %h want 04", IN_PORT); else n_pass++;
    n_checks++; if (INTERUPT !== 1'b0) $display("FAIL rot_int: got %b want 0", INTERUPT); else n_pass++;
    repeat (23) step();
    n_checks++; if (INTERUPT !== 1'b0) $display("FAIL rot_early: got %b want 0", INTERUPT); else n_pass++;
    step();
    n_checks++; if (INTERUPT !== 1'b1) $display("FAIL rot_rise: got %b want 1", INTERUPT); else n_pass++;
    PORT_ID = 8'h00;
  endtask

  initial begin
    RESET = 1'b1; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
    SWITCHES = 8'h00; BUTTONS = 4'h0;
    test_reset();
    test_port_writes();
    test_in_port();
    test_timer_period();
    test_timer_random();
    test_freeze();
    test_button();
    test_reset_midcount();
    test_reload_on_tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rat_io_responder.md
RAT_IO_RESPONDER -- requirements
Module: rat_io_responder

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- PRESCALE, 1000, clocks per timer tick (range 2..65535).
- LEDS_ID, 8'h40, LED output port.
- SSEG_ID, 8'h81, seven-segment data output port.
- TMR_RLD_ID, 8'h10, timer reload port (write); timer count (read).
- TMR_CTL_ID, 8'h11, timer control port, bit0 = enable (write).
- INT_ACK_ID, 8'h12, interrupt acknowledge port (write).
- SW_ID, 8'h20, switch input port (read).
- BTN_ID, 8'h21, button input port (read).
- STAT_ID, 8'h22, status port (read).
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- CLK, in, 1, system clock; all state updates on rising edge.
- RESET, in, 1, synchronous active-high reset (already decided).
- PORT_ID, in, 8, MCU port address.
- OUT_PORT, in, 8, MCU write data.
- IO_STRB, in, 1, MCU write strobe; one-cycle pulse per OUTPUT instruction.
- SWITCHES, in, 8, board switches (quasi-static).
- BUTTONS, in, 4, board buttons (asynchronous).
- IN_PORT, out, 8, read data to the MCU.
- LEDS, out, 8, registered LED value.
- SSEG_DATA, out, 8, registered seven-segment value.
- INTERUPT, out, 1, level interrupt request to the MCU.

Function
REQ-003 Write SHALL occur on a rising CLK with IO_STRB=1; the register selected by PORT_ID SHALL take OUT_PORT; IO_STRB=0 or an unmatched PORT_ID SHALL change nothing.
REQ-004 LEDS and SSEG_DATA SHALL update one cycle after their write strobe and hold until the next write or RESET.
REQ-005 IN_PORT SHALL be combinational from PORT_ID, as follows:
- SW_ID -> SWITCHES.
- BTN_ID -> {4'h0, btn_sync}.
- STAT_ID -> {5'h0, tmr_en, btn_pend, tmr_pend}.
- TMR_RLD_ID -> current tmr_cnt.
- Any other ID -> 8'h00.
REQ-006 BUTTONS SHALL pass through a 2-flop synchronizer (btn_sync), giving 2 cycles of latency; a btn_sync[0] 0->1 transition SHALL set btn_pend on the following edge.
REQ-007 A write to TMR_RLD_ID SHALL load tmr_rld and tmr_cnt with OUT_PORT and clear the prescaler, taking effect on the next edge.
REQ-008 A write to TMR_CTL_ID SHALL set tmr_en=OUT_PORT[0]; disabling SHALL freeze tmr_cnt and the prescaler, and re-enabling SHALL resume from the frozen values.
REQ-009 While tmr_en=1, the prescaler SHALL count 0..PRESCALE-1 and wrap; a tick is the cycle in which it wraps.
REQ-010 On a tick with tmr_cnt!=0, tmr_cnt SHALL decrement by 1.
REQ-011 On a tick with tmr_cnt==0, tmr_cnt SHALL reload from tmr_rld and tmr_pend SHALL set; tmr_rld=0 therefore yields one interrupt per tick.
REQ-012 Timer period SHALL be (tmr_rld+1)*PRESCALE clocks.
REQ-013 INTERUPT SHALL equal the registered value (tmr_pend | btn_pend) and hold until acknowledged.
REQ-014 A write to INT_ACK_ID SHALL clear tmr_pend if OUT_PORT[0]=1 and btn_pend if OUT_PORT[1]=1.
REQ-015 When a set and a clear of the same pend bit occur on the same edge, the set SHALL win.
REQ-016 A reload write coinciding with a tick SHALL take priority over the tick, and no pend SHALL be set on that edge.
REQ-017 All state arithmetic SHALL be 8-bit unsigned; the prescaler SHALL be wide enough for PRESCALE-1.

Reset
REQ-018 On RESET=1 at a rising edge, the following SHALL all reset to 0, overriding any simultaneous IO_STRB write:
- LEDS, SSEG_DATA, tmr_rld, tmr_cnt, prescaler, tmr_en.
- tmr_pend, btn_pend, btn_sync.
- INTERUPT (hence low one cycle later).
REQ-019 RESET asserted while the timer is running SHALL stop it; no tick or pend SHALL follow until it is re-enabled.

Verification (PRESCALE=4)
REQ-020 A bench SHALL apply PORT_ID=8'h40, OUT_PORT=8'hA5, IO_STRB=1 for 1 cycle -> LEDS=8'hA5 next cycle; the same with PORT_ID=8'h41 -> LEDS unchanged.
REQ-021 A bench SHALL set SWITCHES=8'h4F, then PORT_ID=8'h20 -> IN_PORT=8'h4F in the same cycle; PORT_ID=8'h99 -> IN_PORT=8'h00.
REQ-022 A bench SHALL write reload=3, then ctl=1 -> INTERUPT rises 16 clocks after the enable edge; ack 8'h01 -> INTERUPT low next cycle; it rises again 16 clocks after the previous rise.
REQ-023 A bench SHALL raise BUTTONS[0] -> INTERUPT=1 three cycles later with STAT=8'h02; writing ack 8'h02 in the same cycle as a new button edge -> btn_pend stays 1.
REQ-024 A bench SHALL assert RESET mid-count with pend set -> LEDS=0, INTERUPT=0, and STAT=8'h00 after one edge, with no interrupt for 40 clocks afterward.
REQ-025 A bench SHALL write reload=5 on the tick cycle where tmr_cnt==0 -> tmr_cnt=5 with no pend set.
